interrupt_ctrl: RTL and testbench
=================================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous, active-low reset: CLK is the single clock (all state on rising edge); RST_N is the asynchronous active-low reset.
REQ-002 CLK  in  1  system clock.
REQ-003 RST_N  in  1  asynchronous reset, active low.
REQ-004 NMI_N  in  1  non-maskable interrupt pin, asynchronous, falling-edge sensitive.
REQ-005 IRQ_N  in  1  maskable interrupt pin, asynchronous, low-level sensitive.
REQ-006 P_IN  in  8  current status register value (PSR OUT); bit 2 = I flag.
REQ-007 BRK_REQ  in  1  decoder flags current opcode as BRK.
REQ-008 INSTR_DONE  in  1  one-cycle strobe at instruction boundary.
REQ-009 SEQ_ACTIVE  out  1  high while any interrupt/reset sequence runs.
REQ-010 PUSH_PCH, PUSH_PCL, PUSH_P  out  1 each  stack write strobes, one cycle each.
REQ-011 PUSH_DATA  out  8  status byte for PUSH_P; valid only while PUSH_P high.
REQ-012 FETCH_VL, FETCH_VH  out  1 each  vector low/high byte read strobes.
REQ-013 VEC_ADDR  out  16  vector byte address; valid during FETCH_VL/FETCH_VH.
REQ-014 I_SET  out  1  one-cycle strobe driving the PSR I-load path (set I).
REQ-015 SEQ_DONE  out  1  one-cycle strobe in final sequence cycle.
REQ-016 NMI_PENDING  out  1  latched NMI edge awaiting service.

Function
REQ-017 NMI_N and IRQ_N SHALL each pass a 2-flop synchronizer before use.
REQ-018 A high-to-low transition of synchronized NMI_N SHALL set NMI_PENDING at the 3rd rising CLK edge after the pin falls; a held-low NMI_N SHALL not re-trigger until it returns high.
REQ-019 IRQ SHALL be taken only if synchronized IRQ_N is low and P_IN[2]=0 in the INSTR_DONE cycle.
REQ-020 FSM states: IDLE, RST0, RST1, RST2, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H; one cycle per non-IDLE state.
REQ-021 In IDLE with INSTR_DONE=1, priority NMI_PENDING > BRK_REQ > IRQ; winner moves FSM to PUSH_H next edge; none -> stay IDLE.
REQ-022 Interrupt path: PUSH_H -> PUSH_L -> PUSH_P -> VEC_L -> VEC_H -> IDLE; each push strobe high only in its state.
REQ-023 PUSH_DATA SHALL equal P_IN with bit 5 forced 1 and bit 4 = 1 for BRK, 0 for NMI/IRQ.
REQ-024 VEC_ADDR: NMI 16'hFFFA/16'hFFFB, IRQ/BRK 16'hFFFE/16'hFFFF, reset 16'hFFFC/16'hFFFD (low byte in VEC_L, high in VEC_H).
REQ-025 NMI hijack: NMI_PENDING set during BRK/IRQ sequence at or before PUSH_P SHALL switch vector to FFFA/FFFB; B bit in PUSH_DATA stays as started.
REQ-026 NMI_PENDING SHALL clear on entering VEC_L of any sequence using the NMI vector; a new edge in that same cycle SHALL set it again (set wins).
REQ-027 I_SET and FETCH_VL SHALL assert together in VEC_L; FETCH_VH and SEQ_DONE in VEC_H.
REQ-028 SEQ_ACTIVE = (state != IDLE); INSTR_DONE and BRK_REQ ignored while SEQ_ACTIVE.
REQ-029 Total interrupt sequence latency: 5 cycles from leaving IDLE to return to IDLE.

Reset
REQ-030 RST_N low SHALL asynchronously force state RST0, NMI_PENDING=0, synchronizer flops=1, all strobes 0, VEC_ADDR=16'hFFFC, SEQ_ACTIVE=1.
REQ-031 After RST_N rises: RST0 -> RST1 -> RST2 -> VEC_L -> VEC_H -> IDLE with no push strobes; vector FFFC/FFFD; I_SET in VEC_L.
REQ-032 RST_N asserted mid-sequence SHALL abort it; no partial push/fetch strobe completes.

Verification
REQ-033 Release reset -> cycles 1-3 all strobes 0, cycle 4 FETCH_VL=1 VEC_ADDR=FFFC I_SET=1, cycle 5 FETCH_VH=1 VEC_ADDR=FFFD SEQ_DONE=1, then IDLE.
REQ-034 P_IN=8'h00, IRQ_N low, INSTR_DONE pulse -> PUSH_PCH, PUSH_PCL, PUSH_P (PUSH_DATA=8'h20), VEC FFFE/FFFF, I_SET once.
REQ-035 P_IN=8'h04, IRQ_N low, INSTR_DONE -> stays IDLE, no strobes.
REQ-036 BRK_REQ+INSTR_DONE, P_IN=8'hC3 -> PUSH_DATA=8'hF3, vector FFFE; repeat with NMI_N falling 4 cycles before PUSH_P -> vector FFFA, PUSH_DATA still 8'hF3, NMI_PENDING clears in VEC_L.
REQ-037 NMI_N falls, held low 20 cycles, one INSTR_DONE -> exactly one NMI sequence (FFFA); second INSTR_DONE -> no sequence.
REQ-038 RST_N pulsed low during PUSH_L of IRQ sequence -> all strobes 0 immediately, reset sequence FFFC/FFFD follows release.

Source files
------------

// File: rtl/interrupt_ctrl.sv
// Interrupt/reset sequencer: synchronizes the NMI and IRQ pins, arbitrates at
// instruction boundaries and steps the stack-push and vector-fetch sequence.
module interrupt_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic [7:0]  p_in,
    input  logic        brk_req,
    input  logic        instr_done,
    output logic        seq_active,
    output logic        push_pch,
    output logic        push_pcl,
    output logic        push_p,
    output logic [7:0]  push_data,
    output logic        fetch_vl,
    output logic        fetch_vh,
    output logic [15:0] vec_addr,
    output logic        i_set,
    output logic        seq_done,
    output logic        nmi_pending
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST0,
        ST_RST1,
        ST_RST2,
        ST_PUSH_H,
        ST_PUSH_L,
        ST_PUSH_P,
        ST_VEC_L,
        ST_VEC_H
    } state_t;

    typedef enum logic [1:0] {
        VEC_RESET,
        VEC_IRQ,
        VEC_NMI
    } vec_src_t;

    state_t   state, state_next;
    vec_src_t vec_src, vec_src_next;
    logic     brk_flag, brk_flag_next;

    logic nmi_s1, nmi_s2, nmi_s3;
    logic irq_s1, irq_s2;
    logic nmi_fall;
    logic irq_take;
    logic nmi_clear;
    logic [15:0] vec_base;

    // nmi_s3 only remembers the previous synchronized level for edge detection.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_s1 <= 1'b1;
            nmi_s2 <= 1'b1;
            nmi_s3 <= 1'b1;
            irq_s1 <= 1'b1;
            irq_s2 <= 1'b1;
        end else begin
            nmi_s1 <= nmi_n;
            nmi_s2 <= nmi_s1;
            nmi_s3 <= nmi_s2;
            irq_s1 <= irq_n;
            irq_s2 <= irq_s1;
        end
    end

    assign nmi_fall = nmi_s3 & ~nmi_s2;
    assign irq_take = ~irq_s2 & ~p_in[2];

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        vec_src_next  = vec_src;
        brk_flag_next = brk_flag;
        case (state)
            ST_IDLE: begin
                if (instr_done) begin
                    if (nmi_pending) begin
                        state_next    = ST_PUSH_H;
                        vec_src_next  = VEC_NMI;
                        brk_flag_next = 1'b0;
                    end else if (brk_req) begin
                        state_next    = ST_PUSH_H;
                        vec_src_next  = VEC_IRQ;
                        brk_flag_next = 1'b1;
                    end else if (irq_take) begin
                        state_next    = ST_PUSH_H;
                        vec_src_next  = VEC_IRQ;
                        brk_flag_next = 1'b0;
                    end
                end
            end
            ST_RST0:   state_next = ST_RST1;
            ST_RST1:   state_next = ST_RST2;
            ST_RST2:   state_next = ST_VEC_L;
            ST_PUSH_H: state_next = ST_PUSH_L;
            ST_PUSH_L: state_next = ST_PUSH_P;
            ST_PUSH_P: begin
                // A pending NMI hijacks a BRK/IRQ sequence up to the last push.
                state_next = ST_VEC_L;
                if (nmi_pending) begin
                    vec_src_next = VEC_NMI;
                end
            end
            ST_VEC_L:  state_next = ST_VEC_H;
            ST_VEC_H:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RST0;
            vec_src  <= VEC_RESET;
            brk_flag <= 1'b0;
        end else begin
            state    <= state_next;
            vec_src  <= vec_src_next;
            brk_flag <= brk_flag_next;
        end
    end

    // Serviced on entry to VEC_L; a coincident new edge keeps it set.
    assign nmi_clear = (state == ST_PUSH_P) && (vec_src_next == VEC_NMI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_pending <= 1'b0;
        end else if (nmi_fall) begin
            nmi_pending <= 1'b1;
        end else if (nmi_clear) begin
            nmi_pending <= 1'b0;
        end
    end

    always_comb begin
        case (vec_src)
            VEC_NMI: vec_base = 16'hFFFA;
            VEC_IRQ: vec_base = 16'hFFFE;
            default: vec_base = 16'hFFFC;
        endcase
    end

    assign seq_active = (state != ST_IDLE);
    assign push_pch   = (state == ST_PUSH_H);
    assign push_pcl   = (state == ST_PUSH_L);
    assign push_p     = (state == ST_PUSH_P);
    assign fetch_vl   = (state == ST_VEC_L);
    assign fetch_vh   = (state == ST_VEC_H);
    assign i_set      = fetch_vl;
    assign seq_done   = fetch_vh;
    assign vec_addr   = {vec_base[15:1], fetch_vh};
    assign push_data  = push_p ? {p_in[7:6], 1'b1, brk_flag, p_in[3:0]} : 8'h00;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: directed scenarios plus randomized
// pin/strobe activity compared against a sequence-level reference model.
module tb_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nmi_n;
    logic        irq_n;
    logic [7:0]  p_in;
    logic        brk_req;
    logic        instr_done;
    logic        seq_active;
    logic        push_pch;
    logic        push_pcl;
    logic        push_p;
    logic [7:0]  push_data;
    logic        fetch_vl;
    logic        fetch_vh;
    logic [15:0] vec_addr;
    logic        i_set;
    logic        seq_done;
    logic        nmi_pending;

    int n_checks = 0;
    int n_pass   = 0;
    int n_iset   = 0;
    int iset_mark;

    // Reference model: which sequence runs and how far into it we are.
    typedef enum {K_NONE, K_RESET, K_INT} kind_t;
    kind_t m_kind;
    int    m_pos;
    logic  m_nmi_vec;
    logic  m_brk;
    logic  m_pend;
    logic  nmi_hist[$];
    logic  irq_hist[$];

    always #5 clk = ~clk;

    interrupt_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .nmi_n       (nmi_n),
        .irq_n       (irq_n),
        .p_in        (p_in),
        .brk_req     (brk_req),
        .instr_done  (instr_done),
        .seq_active  (seq_active),
        .push_pch    (push_pch),
        .push_pcl    (push_pcl),
        .push_p      (push_p),
        .push_data   (push_data),
        .fetch_vl    (fetch_vl),
        .fetch_vh    (fetch_vh),
        .vec_addr    (vec_addr),
        .i_set       (i_set),
        .seq_done    (seq_done),
        .nmi_pending (nmi_pending)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [8:0] exp_flags();
        logic busy;
        logic intr;
        busy = (m_kind != K_NONE);
        intr = (m_kind == K_INT);
        return {busy, intr && m_pos == 0, intr && m_pos == 1, intr && m_pos == 2,
                busy && m_pos == 3, busy && m_pos == 4,
                busy && m_pos == 3, busy && m_pos == 4, m_pend};
    endfunction

    function automatic logic [15:0] exp_vec();
        logic [15:0] v;
        if (m_kind == K_RESET)  v = 16'hFFFC;
        else if (m_nmi_vec)     v = 16'hFFFA;
        else                    v = 16'hFFFE;
        return (m_pos == 4) ? v + 16'd1 : v;
    endfunction

    task automatic check_outputs();
        logic [8:0] act;
        act = {seq_active, push_pch, push_pcl, push_p, fetch_vl, fetch_vh,
               i_set, seq_done, nmi_pending};
        check("flags", 32'(act), 32'(exp_flags()));
        if (m_kind == K_INT && m_pos == 2)
            check("push_data", 32'(push_data),
                  32'((p_in & 8'hEF) | 8'h20 | (m_brk ? 8'h10 : 8'h00)));
        if (m_kind != K_NONE && m_pos >= 3)
            check("vec_addr", 32'(vec_addr), 32'(exp_vec()));
    endtask

    task automatic model_reset();
        m_kind    = K_RESET;
        m_pos     = 0;
        m_nmi_vec = 1'b0;
        m_brk     = 1'b0;
        m_pend    = 1'b0;
        nmi_hist  = '{1'b1, 1'b1, 1'b1};
        irq_hist  = '{1'b1, 1'b1, 1'b1};
    endtask

    // Advance the model across one clock edge using the inputs held before it.
    // A pin level reaches the logic two edges after it is sampled.
    task automatic model_step();
        logic fall;
        logic irq_seen;
        logic clr;
        fall     = (nmi_hist[$-1] == 1'b0) && (nmi_hist[$-2] == 1'b1);
        irq_seen = irq_hist[$-1];
        clr      = 1'b0;
        if (m_kind == K_NONE) begin
            if (instr_done) begin
                if (m_pend) begin
                    m_kind = K_INT; m_pos = 0; m_nmi_vec = 1'b1; m_brk = 1'b0;
                end else if (brk_req) begin
                    m_kind = K_INT; m_pos = 0; m_nmi_vec = 1'b0; m_brk = 1'b1;
                end else if (!irq_seen && !p_in[2]) begin
                    m_kind = K_INT; m_pos = 0; m_nmi_vec = 1'b0; m_brk = 1'b0;
                end
            end
        end else if (m_pos == 4) begin
            m_kind = K_NONE;
        end else begin
            if (m_kind == K_INT && m_pos == 2) begin
                if (m_pend) m_nmi_vec = 1'b1;
                clr = m_nmi_vec;
            end
            m_pos++;
        end
        m_pend = fall || (m_pend && !clr);
        nmi_hist.push_back(nmi_n);
        irq_hist.push_back(irq_n);
        if (nmi_hist.size() > 8) void'(nmi_hist.pop_front());
        if (irq_hist.size() > 8) void'(irq_hist.pop_front());
    endtask

    task automatic cycle(input logic nmi, input logic irq, input logic brk,
                         input logic idone, input logic [7:0] p);
        nmi_n      = nmi;
        irq_n      = irq;
        brk_req    = brk;
        instr_done = idone;
        p_in       = p;
        @(posedge clk);
        #2;
        if (i_set) n_iset++;
        model_step();
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(nmi_n, irq_n, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        nmi_n      = 1'b1;
        irq_n      = 1'b1;
        brk_req    = 1'b0;
        instr_done = 1'b0;
        p_in       = 8'h00;
        #1;
        model_reset();
        check_outputs();
        check("rst_vec", 32'(vec_addr), 32'h0000_FFFC);
        repeat (2) @(posedge clk);
        #2;
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        #3;
        apply_reset();

        // Power-on reset sequence: three quiet cycles then the FFFC/FFFD fetch.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("r_vl", 32'({fetch_vl, i_set, vec_addr}), 32'({2'b11, 16'hFFFC}));
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("r_vh", 32'({fetch_vh, seq_done, vec_addr}), 32'({2'b11, 16'hFFFD}));
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("r_idle", 32'(seq_active), 32'(0));

        // IRQ taken with I clear.
        idle(2);
        iset_mark = n_iset;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        check("irq_pch", 32'(push_pch), 32'(1));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("irq_pdata", 32'(push_data), 32'h0000_0020);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("irq_vl", 32'(vec_addr), 32'h0000_FFFE);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("irq_vh", 32'(vec_addr), 32'h0000_FFFF);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("irq_iset", 32'(n_iset - iset_mark), 32'(1));

        // IRQ masked by I flag.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h04);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h04);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h04);
        check("irq_masked", 32'({seq_active, push_pch}), 32'(0));
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h04);
        idle(2);

        // BRK, then BRK hijacked by an NMI edge four cycles before PUSH_P.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'hC3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
        check("brk_pdata", 32'(push_data), 32'h0000_00F3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
        check("brk_vl", 32'(vec_addr), 32'h0000_FFFE);
        idle(4);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'hC3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
        check("hij_pdata", 32'({nmi_pending, push_data}), 32'h0000_01F3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
        check("hij_vl", 32'({nmi_pending, vec_addr}), 32'h0000_FFFA);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(3);

        // NMI held low: exactly one sequence.
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("nmi_pend", 32'(nmi_pending), 32'(1));
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        idle(3);
        check("nmi_vl", 32'(vec_addr), 32'h0000_FFFA);
        idle(2);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("nmi_once", 32'({seq_active, nmi_pending}), 32'(0));
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(3);

        // Reset during PUSH_L of an IRQ sequence.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("abort_pcl", 32'(push_pcl), 32'(1));
        apply_reset();
        idle(3);
        check("abort_vl", 32'({fetch_vl, vec_addr}), 32'({1'b1, 16'hFFFC}));
        idle(2);

        // Randomized activity with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic nm;
            logic iq;
            if ($urandom_range(0, 399) == 0) begin
                apply_reset();
            end else begin
                nm = ($urandom_range(0, 9) == 0) ? ~nmi_n : nmi_n;
                iq = ($urandom_range(0, 5) == 0) ? ~irq_n : irq_n;
                cycle(nm, iq, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                      8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
